y86_bus_tracer: RTL
===================

// Module: y86_bus_tracer
// PURPOSE
//  Passive bus snooper downstream of the y86 sequential core: watches the core's memory bus
//  and current_opcode, classifies each transaction (FETCH/LOAD/STORE), queues trace records
//  in a FIFO drained via valid/ready, and keeps per-kind counters plus halt/overflow flags.
//  Never drives the core's bus; it is the debug/coverage back end for core simulations.
// PARAMETERS
//  DEPTH   16  trace FIFO entries; power of 2, >=2
//  ADDR_W  32  recorded address width (bus_A[ADDR_W-1:0])
//  CNT_W   16  width of each saturating event counter
// PORTS
//  clk             in   1        clock, all logic on rising edge
//  rst             in   1        asynchronous, active-low reset (0 = reset)
//  en              in   1        capture enable; 0 = ignore bus (drain still works)
//  clr             in   1        synchronous clear of FIFO, counters, flags
//  bus_A           in   32       core bus address
//  bus_in          in   32       read data returned to core
//  bus_out         in   32       write data from core
//  bus_RE          in   1        core read strobe
//  bus_WE          in   1        core write strobe
//  current_opcode  in   8        core IR[7:0]
//  trace_valid     out  1        FIFO non-empty
//  trace_ready     in   1        consumer accepts head entry
//  trace_data      out  42+ADDR_W  {kind[1:0], opcode[7:0], addr[ADDR_W-1:0], data[31:0]}
//  fetch_cnt       out  CNT_W    FETCH count
//  load_cnt        out  CNT_W    LOAD count
//  store_cnt       out  CNT_W    STORE count
//  drop_cnt        out  CNT_W    events lost to full FIFO
//  overflow        out  1        sticky: at least one drop
//  halted          out  1        sticky: opcode 8'hF4 observed after a FETCH
// BEHAVIOUR
//  - Reset (rst=0, any time, async): FIFO empty, trace_valid=0, trace_data=0, counters=0,
//    overflow=0, halted=0, class FSM -> IDLE. clr=1 has identical effect, synchronously, and wins
//    over same-cycle event/pop.
//  - Event: en=1 and (bus_RE or bus_WE) in a cycle. bus_WE has priority if both high.
//  - Classification FSM (states IDLE, AFTER_FETCH):
//    STORE: bus_WE; data=bus_out; state -> IDLE.
//    LOAD : bus_RE, state==AFTER_FETCH, current_opcode==8'h8B; data=bus_in; state -> IDLE.
//    FETCH: any other bus_RE; data=bus_in; state -> AFTER_FETCH.
//    Only 8'h8B with mod=1 is a supported load; other 8'h8B encodings are out of scope.
//  - Record captures current_opcode, bus_A[ADDR_W-1:0], data in the event cycle; it is
//    visible on trace_data no earlier than the next cycle (1-cycle push latency).
//  - Counters: +1 per classified event, saturate at 2^CNT_W-1, never wrap; counted even if
//    the record is dropped. drop_cnt also saturates.
//  - FIFO: pop when trace_valid & trace_ready; trace_data = head, stable while valid & !ready.
//    Push and pop same cycle: both happen, count unchanged; when full, a same-cycle pop makes
//    room so the push is accepted. Full, no pop: record dropped, drop_cnt+1, overflow<=1.
//    Pointers are log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare.
//  - halted sets the cycle after current_opcode==8'hF4 while state==AFTER_FETCH; sticky
//    until rst/clr; capture continues.
//  - en=0: no events, FSM holds, draining unaffected.
// STRUCTURE
//  - Package y86_trace_pkg: kind enum (FETCH=2'd0, LOAD=2'd1, STORE=2'd2), OP_LOAD=8'h8B,
//    OP_STORE=8'h89, OP_HALT=8'hF4, trace record width function of ADDR_W.
//  - Sub-module y86_trace_fifo (DEPTH, WIDTH): sync FIFO, async active-low reset, push/pop,
//    full/empty, registered head. Classifier FSM, counters, flags in the top.
// TESTING
//  - Reset mid-drain: 3 entries queued, rst=0 one cycle -> trace_valid=0, all counts 0 same cycle.
//  - Fetch/load pair: RE @A=0x10 op=0x00 data=0x0006458B, then RE @A=0x20 op=0x8B data=0xCAFE ->
//    records FETCH/0x10 and LOAD/0x20/0xCAFE; fetch_cnt=1, load_cnt=1.
//  - Store: WE @A=0x24 bus_out=0x1234 (RE also high) -> one STORE record, store_cnt=1, no read.
//  - Overflow: DEPTH=4, ready=0, 6 fetches -> 4 entries kept, drop_cnt=2, overflow=1; ready=1
//    -> first 4 addresses drained in order, then trace_valid=0.
//  - Full + simultaneous pop/push: FIFO full, ready=1 and new FETCH same cycle -> no drop,
//    still full, new record appears last.
//  - Halt/saturation: CNT_W=4, 20 fetches -> fetch_cnt=15; fetch then op=0xF4 -> halted=1 until clr.

Source files
------------

// File: rtl/y86_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_trace_pkg
// Description : Shared types and constants for the y86 bus tracer. Contains
//               the record kind encoding, the classifier state encoding, the
//               opcodes of interest, and the trace record width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_trace_pkg;

    // Record kind, stored in the top two bits of every trace record.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } trace_kind_e;

    // Classifier state. AFTER_FETCH means the previous bus read was an
    // instruction fetch, so the next read may be the operand of a load.
    typedef enum logic [0:0] {
        ST_IDLE        = 1'b0,
        ST_AFTER_FETCH = 1'b1
    } class_state_e;

    localparam logic [7:0] OP_LOAD  = 8'h8B;
    localparam logic [7:0] OP_STORE = 8'h89;
    localparam logic [7:0] OP_HALT  = 8'hF4;

    // Record layout is {kind[1:0], opcode[7:0], addr[addr_w-1:0], data[31:0]}.
    function automatic int trace_width(input int addr_w);
        return 2 + 8 + addr_w + 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : y86_trace_fifo
// Description : Synchronous FIFO with a registered head output.
//               Ports: clk, rst (async active-low), clr (sync clear),
//               push/din (write), pop (read request, ignored when empty),
//               dout (head entry, 0 when empty), full, empty.
//               A push while full is accepted only if a pop happens in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = pop & ~w_empty;
    assign w_push    = push & (~w_full | w_pop);
    assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // The head register is loaded with whatever will sit at the read pointer
    // after this cycle. When that slot is the one being written right now,
    // the memory does not hold it yet, so forward the incoming data.
    always_comb begin
        w_head_next = r_mem[w_rd_next[AW-1:0]];
        if (w_wr_next == w_rd_next) begin
            w_head_next = '0;
        end else if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_next = din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = r_head;
    assign full  = w_full;
    assign empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/y86_bus_tracer.sv
`default_nettype none
// ============================================================================
// Module      : y86_bus_tracer
// Description : Passive snooper on the y86 core memory bus. Classifies each
//               bus transaction as FETCH, LOAD or STORE, queues a trace record
//               in a FIFO drained over trace_valid/trace_ready, and keeps
//               saturating per-kind counters plus sticky halt/overflow flags.
//               Inputs : clk, rst (async active-low), en, clr, bus_A, bus_in,
//                        bus_out, bus_RE, bus_WE, current_opcode, trace_ready
//               Outputs: trace_valid, trace_data, fetch_cnt, load_cnt,
//                        store_cnt, drop_cnt, overflow, halted
// Revision    : 1.0 - initial release
// ============================================================================
module y86_bus_tracer
    import y86_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             clr,
    input  logic [31:0]                      bus_A,
    input  logic [31:0]                      bus_in,
    input  logic [31:0]                      bus_out,
    input  logic                             bus_RE,
    input  logic                             bus_WE,
    input  logic [7:0]                       current_opcode,
    output logic                             trace_valid,
    input  logic                             trace_ready,
    output logic [trace_width(ADDR_W)-1:0]   trace_data,
    output logic [CNT_W-1:0]                 fetch_cnt,
    output logic [CNT_W-1:0]                 load_cnt,
    output logic [CNT_W-1:0]                 store_cnt,
    output logic [CNT_W-1:0]                 drop_cnt,
    output logic                             overflow,
    output logic                             halted
);

    localparam int REC_W = trace_width(ADDR_W);

    class_state_e            r_state;
    class_state_e            w_state_next;
    trace_kind_e             w_kind;
    logic [31:0]             w_data;
    logic                    w_event;
    logic                    w_pop;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    logic [REC_W-1:0]        w_rec;

    logic [CNT_W-1:0]        r_fetch_cnt;
    logic [CNT_W-1:0]        r_load_cnt;
    logic [CNT_W-1:0]        r_store_cnt;
    logic [CNT_W-1:0]        r_drop_cnt;
    logic                    r_overflow;
    logic                    r_halted;

    assign w_event = en & (bus_RE | bus_WE);

    // Classifier: a write always wins; a read is a load operand only when it
    // directly follows a fetch and the core is executing the load opcode.
    always_comb begin
        w_state_next = r_state;
        w_kind       = FETCH;
        w_data       = bus_in;
        if (w_event) begin
            if (bus_WE) begin
                w_kind       = STORE;
                w_data       = bus_out;
                w_state_next = ST_IDLE;
            end else if (r_state == ST_AFTER_FETCH && current_opcode == OP_LOAD) begin
                w_kind       = LOAD;
                w_state_next = ST_IDLE;
            end else begin
                w_kind       = FETCH;
                w_state_next = ST_AFTER_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_rec  = {w_kind, current_opcode, bus_A[ADDR_W-1:0], w_data};
    assign w_pop  = ~w_empty & trace_ready;
    // A same-cycle pop frees a slot, so only full-without-pop loses the record.
    assign w_drop = w_event & w_full & ~w_pop;

    y86_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (w_event),
        .din   (w_rec),
        .pop   (w_pop),
        .dout  (trace_data),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_halted    <= 1'b0;
        end else if (clr) begin
            r_fetch_cnt <= '0;
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (w_event && w_kind == FETCH && r_fetch_cnt != '1) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
            if (w_event && w_kind == LOAD && r_load_cnt != '1) begin
                r_load_cnt <= r_load_cnt + CNT_W'(1);
            end
            if (w_event && w_kind == STORE && r_store_cnt != '1) begin
                r_store_cnt <= r_store_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
            if (r_state == ST_AFTER_FETCH && current_opcode == OP_HALT) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign trace_valid = ~w_empty;
    assign fetch_cnt   = r_fetch_cnt;
    assign load_cnt    = r_load_cnt;
    assign store_cnt   = r_store_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign overflow    = r_overflow;
    assign halted      = r_halted;

endmodule
`default_nettype wire
